axi_arbiter_2m: RTL and testbench
=================================

AXI_ARBITER_2M -- requirements
Module: axi_arbiter_2m

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles in WRITE/READ before forced abort; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mN_aw_valid, mN_w_valid, mN_b_ready, mN_ar_valid, mN_r_ready (N=0,1)  input  1 each  master-side requests/acceptances.
REQ-005 mN_aw_addr, mN_ar_addr (N=0,1)  input  3 each  master write/read address.
REQ-006 mN_w_data (N=0,1)  input  4  master write data.
REQ-007 mN_aw_ready, mN_w_ready, mN_b_valid, mN_ar_ready, mN_r_valid (N=0,1)  output  1 each  routed slave responses.
REQ-008 mN_r_data (N=0,1)  output  4  routed read data.
REQ-009 s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready  output  1 each  slave-side channel signals.
REQ-010 s_aw_addr, s_ar_addr  output  3; s_w_data  output  4  slave-side address/data.
REQ-011 s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid  input  1; s_r_data  input  4  slave responses.
REQ-012 grant  output  2  one-hot owner (bit0=m0, bit1=m1), 00 when idle.
REQ-013 busy  output  1  high in WRITE or READ.
REQ-014 timeout_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 State machine states: IDLE, WRITE, READ; state, grant, owner kind, and round-robin pointer are registers.
REQ-016 Master N requests when mN_aw_valid or mN_ar_valid is high.
REQ-017 In IDLE with any request, the next edge enters WRITE or READ with grant set; grant-to-slave latency is 1 cycle.
REQ-018 Both masters requesting: grant goes to the master other than the last owner (round-robin); a lone requester always wins.
REQ-019 Owner with both aw_valid and ar_valid: WRITE is chosen; the read waits for a later arbitration.
REQ-020 In WRITE, the owner's aw/w signals drive the slave, and s_aw_ready/s_w_ready/s_b_valid route back to the owner only.
REQ-021 In READ, the owner's ar/r signals drive the slave, and s_ar_ready/s_r_valid/s_r_data route back to the owner only.
REQ-022 Channels not belonging to the active transaction: slave-side valids 0, readies 0, addr/data 0.
REQ-023 Non-owner outputs: all ready/valid 0, and mN_r_data 0 for the non-owner.
REQ-024 In WRITE, s_aw_valid is masked after the AW handshake and s_w_valid after the W handshake, tracked by aw_done/w_done flags, so no channel is issued twice.
REQ-025 In WRITE, s_b_valid&s_b_ready completes the transaction: return to IDLE, pointer := owner, grant := 00.
REQ-026 In READ, s_ar_valid is masked after the AR handshake; s_r_valid&s_r_ready completes the transaction with the same IDLE update.
REQ-027 IDLE is held for exactly one cycle after completion, so back-to-back transactions have one bubble.
REQ-028 Timeout counter clears on entry to WRITE/READ and increments each cycle; at count==TIMEOUT (TIMEOUT>0) the block aborts to IDLE, pulses timeout_err, and advances the pointer.
REQ-029 A request deasserted before its handshake does not cancel the transaction; only completion, timeout, or reset ends it.

Reset
REQ-030 rst_n low forces, asynchronously and mid-transaction, state=IDLE, grant=00, busy=0, timeout_err=0, aw_done=w_done=0, pointer=m1 (m0 wins first tie), counter=0, and every output to 0.

Verification
REQ-031 Reset release, both masters assert aw_valid (m0 addr 3'd2 data 4'hA, m1 addr 3'd5 data 4'h3) -> m0 granted first, slave sees addr 2/data A; after B, m1 granted and slave sees 5/3.
REQ-032 m1 alone issues a read, ar_addr 3'd4, slave returns 4'h7 -> grant=10, m1_r_data=7 with m1_r_valid; m0_r_valid stays 0.
REQ-033 m0 asserts aw_valid and ar_valid together -> WRITE first; READ follows after one IDLE cycle.
REQ-034 Slave accepts AW two cycles before W -> s_aw_valid drops after the AW handshake and the write completes on B.
REQ-035 TIMEOUT=4, slave never asserts s_b_valid -> abort after 4 cycles in WRITE, one-cycle timeout_err pulse, grant=00.
REQ-036 rst_n pulsed low during READ -> all outputs 0 immediately, and the next tie goes to m0.

Source files
------------

// File: rtl/axi_arbiter_2m.sv
// Two-master to one-slave AXI-lite style arbiter with round-robin ownership,
// write-over-read priority, per-channel issue masking and an abort timeout.
module axi_arbiter_2m #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_aw_valid,
    input  logic [2:0] m0_aw_addr,
    input  logic       m0_w_valid,
    input  logic [3:0] m0_w_data,
    input  logic       m0_b_ready,
    input  logic       m0_ar_valid,
    input  logic [2:0] m0_ar_addr,
    input  logic       m0_r_ready,
    input  logic       m1_aw_valid,
    input  logic [2:0] m1_aw_addr,
    input  logic       m1_w_valid,
    input  logic [3:0] m1_w_data,
    input  logic       m1_b_ready,
    input  logic       m1_ar_valid,
    input  logic [2:0] m1_ar_addr,
    input  logic       m1_r_ready,
    output logic       m0_aw_ready,
    output logic       m0_w_ready,
    output logic       m0_b_valid,
    output logic       m0_ar_ready,
    output logic       m0_r_valid,
    output logic [3:0] m0_r_data,
    output logic       m1_aw_ready,
    output logic       m1_w_ready,
    output logic       m1_b_valid,
    output logic       m1_ar_ready,
    output logic       m1_r_valid,
    output logic [3:0] m1_r_data,
    output logic       s_aw_valid,
    output logic [2:0] s_aw_addr,
    output logic       s_w_valid,
    output logic [3:0] s_w_data,
    output logic       s_b_ready,
    output logic       s_ar_valid,
    output logic [2:0] s_ar_addr,
    output logic       s_r_ready,
    input  logic       s_aw_ready,
    input  logic       s_w_ready,
    input  logic       s_b_valid,
    input  logic       s_ar_ready,
    input  logic       s_r_valid,
    input  logic [3:0] s_r_data,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // The abort edge is the one on which the counter would reach TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]    state_reg;
    logic [1:0]    grant_reg;
    logic          ptr_reg;
    logic          aw_done_reg;
    logic          w_done_reg;
    logic          ar_done_reg;
    logic [CW-1:0] count_reg;
    logic          timeout_err_reg;

    logic [1:0] aw_valid_m, w_valid_m, b_ready_m, ar_valid_m, r_ready_m, req_m;
    logic [2:0] aw_addr_m [2];
    logic [2:0] ar_addr_m [2];
    logic [3:0] w_data_m  [2];

    assign aw_valid_m   = {m1_aw_valid, m0_aw_valid};
    assign w_valid_m    = {m1_w_valid, m0_w_valid};
    assign b_ready_m    = {m1_b_ready, m0_b_ready};
    assign ar_valid_m   = {m1_ar_valid, m0_ar_valid};
    assign r_ready_m    = {m1_r_ready, m0_r_ready};
    assign aw_addr_m[0] = m0_aw_addr;
    assign aw_addr_m[1] = m1_aw_addr;
    assign ar_addr_m[0] = m0_ar_addr;
    assign ar_addr_m[1] = m1_ar_addr;
    assign w_data_m[0]  = m0_w_data;
    assign w_data_m[1]  = m1_w_data;
    assign req_m        = aw_valid_m | ar_valid_m;

    logic owner, in_write, in_read;
    assign owner    = grant_reg[1];
    assign in_write = (state_reg == ST_WRITE);
    assign in_read  = (state_reg == ST_READ);

    assign s_aw_valid = in_write & aw_valid_m[owner] & ~aw_done_reg;
    assign s_aw_addr  = in_write ? aw_addr_m[owner] : 3'd0;
    assign s_w_valid  = in_write & w_valid_m[owner] & ~w_done_reg;
    assign s_w_data   = in_write ? w_data_m[owner] : 4'd0;
    assign s_b_ready  = in_write & b_ready_m[owner];
    assign s_ar_valid = in_read & ar_valid_m[owner] & ~ar_done_reg;
    assign s_ar_addr  = in_read ? ar_addr_m[owner] : 3'd0;
    assign s_r_ready  = in_read & r_ready_m[owner];

    logic [1:0] aw_ready_m, w_ready_m, b_valid_m, ar_ready_m, r_valid_m;
    logic [3:0] r_data_m [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            logic own_wr, own_rd;
            assign own_wr         = in_write & grant_reg[gi];
            assign own_rd         = in_read & grant_reg[gi];
            assign aw_ready_m[gi] = own_wr & s_aw_ready & ~aw_done_reg;
            assign w_ready_m[gi]  = own_wr & s_w_ready & ~w_done_reg;
            assign b_valid_m[gi]  = own_wr & s_b_valid;
            assign ar_ready_m[gi] = own_rd & s_ar_ready & ~ar_done_reg;
            assign r_valid_m[gi]  = own_rd & s_r_valid;
            assign r_data_m[gi]   = own_rd ? s_r_data : 4'd0;
        end
    endgenerate

    assign m0_aw_ready = aw_ready_m[0];
    assign m0_w_ready  = w_ready_m[0];
    assign m0_b_valid  = b_valid_m[0];
    assign m0_ar_ready = ar_ready_m[0];
    assign m0_r_valid  = r_valid_m[0];
    assign m0_r_data   = r_data_m[0];
    assign m1_aw_ready = aw_ready_m[1];
    assign m1_w_ready  = w_ready_m[1];
    assign m1_b_valid  = b_valid_m[1];
    assign m1_ar_ready = ar_ready_m[1];
    assign m1_r_valid  = r_valid_m[1];
    assign m1_r_data   = r_data_m[1];

    logic aw_hs, w_hs, ar_hs, xfer_done, timed_out, win;
    assign aw_hs     = s_aw_valid & s_aw_ready;
    assign w_hs      = s_w_valid & s_w_ready;
    assign ar_hs     = s_ar_valid & s_ar_ready;
    assign xfer_done = (s_b_valid & s_b_ready) | (s_r_valid & s_r_ready);
    // A completion landing on the timeout edge is honoured, not aborted.
    assign timed_out = (TIMEOUT != 0) && (state_reg != ST_IDLE)
                       && (count_reg == CNT_LAST) && !xfer_done;
    // ptr_reg holds the last owner; on a tie the other master wins.
    assign win       = (req_m == 2'b11) ? ~ptr_reg : req_m[1];

    assign grant       = grant_reg;
    assign busy        = in_write | in_read;
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= 2'b00;
            ptr_reg         <= 1'b1;
            aw_done_reg     <= 1'b0;
            w_done_reg      <= 1'b0;
            ar_done_reg     <= 1'b0;
            count_reg       <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req_m) begin
                        state_reg   <= aw_valid_m[win] ? ST_WRITE : ST_READ;
                        grant_reg   <= win ? 2'b10 : 2'b01;
                        count_reg   <= '0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        ar_done_reg <= 1'b0;
                    end
                end
                ST_WRITE, ST_READ: begin
                    count_reg <= count_reg + 1'b1;
                    if (aw_hs) aw_done_reg <= 1'b1;
                    if (w_hs)  w_done_reg  <= 1'b1;
                    if (ar_hs) ar_done_reg <= 1'b1;
                    if (xfer_done || timed_out) begin
                        state_reg       <= ST_IDLE;
                        grant_reg       <= 2'b00;
                        ptr_reg         <= owner;
                        aw_done_reg     <= 1'b0;
                        w_done_reg      <= 1'b0;
                        ar_done_reg     <= 1'b0;
                        timeout_err_reg <= timed_out;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_arbiter_2m.sv
// Bench for axi_arbiter_2m: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model sampled on the falling edge.
module tb_axi_arbiter_2m;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic m0_aw_valid, m0_w_valid, m0_b_ready, m0_ar_valid, m0_r_ready;
    logic m1_aw_valid, m1_w_valid, m1_b_ready, m1_ar_valid, m1_r_ready;
    logic [2:0] m0_aw_addr, m0_ar_addr, m1_aw_addr, m1_ar_addr;
    logic [3:0] m0_w_data, m1_w_data;
    logic m0_aw_ready, m0_w_ready, m0_b_valid, m0_ar_ready, m0_r_valid;
    logic m1_aw_ready, m1_w_ready, m1_b_valid, m1_ar_ready, m1_r_valid;
    logic [3:0] m0_r_data, m1_r_data;
    logic s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
    logic [2:0] s_aw_addr, s_ar_addr;
    logic [3:0] s_w_data;
    logic s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
    logic [3:0] s_r_data;
    logic [1:0] grant;
    logic busy, timeout_err;

    axi_arbiter_2m #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_aw_valid(m0_aw_valid), .m0_aw_addr(m0_aw_addr), .m0_w_valid(m0_w_valid),
        .m0_w_data(m0_w_data), .m0_b_ready(m0_b_ready), .m0_ar_valid(m0_ar_valid),
        .m0_ar_addr(m0_ar_addr), .m0_r_ready(m0_r_ready),
        .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_w_valid(m1_w_valid),
        .m1_w_data(m1_w_data), .m1_b_ready(m1_b_ready), .m1_ar_valid(m1_ar_valid),
        .m1_ar_addr(m1_ar_addr), .m1_r_ready(m1_r_ready),
        .m0_aw_ready(m0_aw_ready), .m0_w_ready(m0_w_ready), .m0_b_valid(m0_b_valid),
        .m0_ar_ready(m0_ar_ready), .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data),
        .m1_aw_ready(m1_aw_ready), .m1_w_ready(m1_w_ready), .m1_b_valid(m1_b_valid),
        .m1_ar_ready(m1_ar_ready), .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data),
        .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_w_valid(s_w_valid),
        .s_w_data(s_w_data), .s_b_ready(s_b_ready), .s_ar_valid(s_ar_valid),
        .s_ar_addr(s_ar_addr), .s_r_ready(s_r_ready),
        .s_aw_ready(s_aw_ready), .s_w_ready(s_w_ready), .s_b_valid(s_b_valid),
        .s_ar_ready(s_ar_ready), .s_r_valid(s_r_valid), .s_r_data(s_r_data),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {m0_aw_valid, m0_w_valid, m0_b_ready, m0_ar_valid, m0_r_ready} = '0;
        {m1_aw_valid, m1_w_valid, m1_b_ready, m1_ar_valid, m1_r_ready} = '0;
        {m0_aw_addr, m0_ar_addr, m1_aw_addr, m1_ar_addr} = '0;
        {m0_w_data, m1_w_data} = '0;
        {s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid} = '0;
        s_r_data = '0;
    endtask

    task automatic randomize_inputs();
        m0_aw_valid = 1'($urandom_range(0, 1)); m1_aw_valid = 1'($urandom_range(0, 1));
        m0_ar_valid = 1'($urandom_range(0, 1)); m1_ar_valid = 1'($urandom_range(0, 1));
        m0_w_valid  = 1'($urandom_range(0, 1)); m1_w_valid  = 1'($urandom_range(0, 1));
        m0_b_ready  = ($urandom_range(0, 3) != 0); m1_b_ready = ($urandom_range(0, 3) != 0);
        m0_r_ready  = ($urandom_range(0, 3) != 0); m1_r_ready = ($urandom_range(0, 3) != 0);
        m0_aw_addr = 3'($urandom); m0_ar_addr = 3'($urandom); m0_w_data = 4'($urandom);
        m1_aw_addr = 3'($urandom); m1_ar_addr = 3'($urandom); m1_w_data = 4'($urandom);
        s_aw_ready = ($urandom_range(0, 3) != 0); s_w_ready = ($urandom_range(0, 3) != 0);
        s_ar_ready = ($urandom_range(0, 3) != 0);
        s_b_valid  = 1'($urandom_range(0, 1)); s_r_valid = 1'($urandom_range(0, 1));
        s_r_data   = 4'($urandom);
    endtask

    // Reference model: who owns the slave, what kind of transfer, how long
    // it has lasted, and which request channels have already been accepted.
    int m_owner = -1;
    int m_last  = 1;
    int m_age   = 0;
    bit m_write, m_aw_sent, m_w_sent, m_ar_sent, m_terr;

    always @(negedge clk) begin : p_model
        logic [1:0] awv, wv, brdy, arv, rrdy, x_gr;
        logic [1:0] x_awr, x_wr, x_bv, x_arr, x_rv;
        logic [2:0] awa [2];
        logic [2:0] ara [2];
        logic [3:0] wd  [2];
        logic [3:0] x_rd [2];
        logic x_awv, x_wv, x_brdy, x_arv, x_rrdy, x_terr;
        logic [2:0] x_awa, x_ara;
        logic [3:0] x_wd;
        bit fin;
        int o;

        awv = {m1_aw_valid, m0_aw_valid}; wv = {m1_w_valid, m0_w_valid};
        brdy = {m1_b_ready, m0_b_ready};  arv = {m1_ar_valid, m0_ar_valid};
        rrdy = {m1_r_ready, m0_r_ready};
        awa[0] = m0_aw_addr; awa[1] = m1_aw_addr;
        ara[0] = m0_ar_addr; ara[1] = m1_ar_addr;
        wd[0]  = m0_w_data;  wd[1]  = m1_w_data;

        {x_gr, x_awr, x_wr, x_bv, x_arr, x_rv} = '0;
        x_rd[0] = '0; x_rd[1] = '0;
        {x_awv, x_wv, x_brdy, x_arv, x_rrdy} = '0;
        x_awa = '0; x_ara = '0; x_wd = '0;
        x_terr = rst_n && m_terr;
        o = m_owner;

        if (rst_n && o >= 0) begin
            x_gr[o] = 1'b1;
            if (m_write) begin
                x_awv = awv[o] && !m_aw_sent; x_awa = awa[o];
                x_wv  = wv[o] && !m_w_sent;   x_wd  = wd[o];
                x_brdy = brdy[o];
                x_awr[o] = s_aw_ready && !m_aw_sent;
                x_wr[o]  = s_w_ready && !m_w_sent;
                x_bv[o]  = s_b_valid;
            end else begin
                x_arv = arv[o] && !m_ar_sent; x_ara = ara[o];
                x_rrdy = rrdy[o];
                x_arr[o] = s_ar_ready && !m_ar_sent;
                x_rv[o]  = s_r_valid;
                x_rd[o]  = s_r_data;
            end
        end

        check("status", {grant, busy, timeout_err}, {x_gr, (rst_n && o >= 0), x_terr});
        check("slave", {s_aw_valid, s_aw_addr, s_w_valid, s_w_data, s_b_ready,
                        s_ar_valid, s_ar_addr, s_r_ready},
                       {x_awv, x_awa, x_wv, x_wd, x_brdy, x_arv, x_ara, x_rrdy});
        check("m0", {m0_aw_ready, m0_w_ready, m0_b_valid, m0_ar_ready, m0_r_valid, m0_r_data},
                    {x_awr[0], x_wr[0], x_bv[0], x_arr[0], x_rv[0], x_rd[0]});
        check("m1", {m1_aw_ready, m1_w_ready, m1_b_valid, m1_ar_ready, m1_r_valid, m1_r_data},
                    {x_awr[1], x_wr[1], x_bv[1], x_arr[1], x_rv[1], x_rd[1]});

        if (!rst_n) begin
            m_owner = -1; m_last = 1; m_age = 0; m_terr = 0;
            {m_aw_sent, m_w_sent, m_ar_sent} = '0;
        end else begin
            m_terr = 0;
            if (o < 0) begin
                if ((awv | arv) != 2'b00) begin
                    if ((awv[0] || arv[0]) && (awv[1] || arv[1])) o = 1 - m_last;
                    else o = (awv[1] || arv[1]) ? 1 : 0;
                    m_owner = o; m_write = awv[o]; m_age = 0;
                    {m_aw_sent, m_w_sent, m_ar_sent} = '0;
                end
            end else begin
                m_age++;
                if (x_awv && s_aw_ready) m_aw_sent = 1;
                if (x_wv && s_w_ready)   m_w_sent  = 1;
                if (x_arv && s_ar_ready) m_ar_sent = 1;
                fin = m_write ? (s_b_valid && brdy[o]) : (s_r_valid && rrdy[o]);
                if (fin || (TO > 0 && m_age == int'(TO))) begin
                    n_txn++;
                    $display("txn %0d: m%0d %s %s after %0d cycles", n_txn, o,
                             m_write ? "write" : "read", fin ? "completed" : "timed out", m_age);
                    m_last = o; m_owner = -1; m_terr = !fin;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) cyc();
        @(negedge clk);
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        cyc();
        rst_n = 1'b1;

        // Both masters write at once: m0 first, then m1 by round-robin.
        m0_aw_valid = 1; m0_aw_addr = 3'd2; m0_w_valid = 1; m0_w_data = 4'hA; m0_b_ready = 1;
        m1_aw_valid = 1; m1_aw_addr = 3'd5; m1_w_valid = 1; m1_w_data = 4'h3; m1_b_ready = 1;
        s_aw_ready = 1; s_w_ready = 1;
        @(negedge clk); check("t1_idle", grant, 2'b00);
        cyc(); @(negedge clk);
        check("t1_grant_m0", grant, 2'b01);
        check("t1_aw_addr", s_aw_addr, 3'd2);
        check("t1_w_data", s_w_data, 4'hA);
        cyc(); s_b_valid = 1; @(negedge clk);
        check("t1_aw_mask", s_aw_valid, 1'b0);
        check("t1_b_route", {m1_b_valid, m0_b_valid}, 2'b01);
        cyc(); s_b_valid = 0; @(negedge clk);
        check("t1_bubble", grant, 2'b00);
        cyc(); @(negedge clk);
        check("t1_grant_m1", grant, 2'b10);
        check("t1_aw_addr1", s_aw_addr, 3'd5);
        check("t1_w_data1", s_w_data, 4'h3);
        cyc(); m0_aw_valid = 0; m0_w_valid = 0; s_b_valid = 1;
        cyc(); clear_inputs();
        cyc();

        // m1 read alone.
        m1_ar_valid = 1; m1_ar_addr = 3'd4; m1_r_ready = 1; m0_r_ready = 1;
        s_ar_ready = 1; s_r_valid = 1; s_r_data = 4'h7;
        cyc(); @(negedge clk);
        check("t2_grant", grant, 2'b10);
        check("t2_ar_addr", s_ar_addr, 3'd4);
        check("t2_m1_r", {m1_r_valid, m1_r_data}, {1'b1, 4'h7});
        check("t2_m0_r", {m0_r_valid, m0_r_data}, 5'd0);
        cyc(); clear_inputs();
        cyc();

        // m0 write and read together: write first, read after one idle cycle.
        m0_aw_valid = 1; m0_ar_valid = 1; m0_w_valid = 1; m0_b_ready = 1; m0_r_ready = 1;
        m0_aw_addr = 3'd6; m0_ar_addr = 3'd1; m0_w_data = 4'h5;
        s_aw_ready = 1; s_w_ready = 1; s_b_valid = 1; s_ar_ready = 1; s_r_valid = 1; s_r_data = 4'h9;
        cyc(); @(negedge clk);
        check("t3_write_first", {grant, s_aw_valid, s_ar_valid}, {2'b01, 1'b1, 1'b0});
        cyc(); m0_aw_valid = 0; m0_w_valid = 0; @(negedge clk);
        check("t3_bubble", busy, 1'b0);
        cyc(); @(negedge clk);
        check("t3_read", {grant, s_ar_valid, s_ar_addr, m0_r_data}, {2'b01, 1'b1, 3'd1, 4'h9});
        cyc(); clear_inputs();
        cyc();

        // AW accepted two cycles before W.
        m0_aw_valid = 1; m0_aw_addr = 3'd1; m0_w_valid = 1; m0_w_data = 4'h6; m0_b_ready = 1;
        s_aw_ready = 1;
        cyc(); @(negedge clk);
        check("t4_aw_up", s_aw_valid, 1'b1);
        cyc(); @(negedge clk);
        check("t4_aw_drop", {s_aw_valid, s_w_valid}, 2'b01);
        cyc(); s_w_ready = 1; s_b_valid = 1; @(negedge clk);
        check("t4_w_pending", {s_aw_valid, s_w_valid, busy}, 3'b011);
        cyc(); clear_inputs(); @(negedge clk);
        check("t4_done", busy, 1'b0);
        cyc();

        // Slave never responds with B: timeout after TO cycles in WRITE.
        m0_aw_valid = 1; m0_w_valid = 1; m0_b_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        cyc();
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("t5_busy", {busy, timeout_err}, 2'b10);
            cyc();
        end
        clear_inputs(); @(negedge clk);
        check("t5_abort", {grant, busy, timeout_err}, {2'b00, 1'b0, 1'b1});
        cyc(); @(negedge clk);
        check("t5_pulse_end", timeout_err, 1'b0);
        cyc();

        // Reset mid-read: outputs drop at once, next tie goes to m0.
        m1_ar_valid = 1; m1_ar_addr = 3'd3; m1_r_ready = 1; s_ar_ready = 1;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1;
        check("t6_async", {grant, busy, m1_ar_ready, m1_r_valid, s_ar_valid, s_ar_addr, s_r_ready},
              11'd0);
        cyc(); rst_n = 1'b1; clear_inputs();
        m0_aw_valid = 1; m0_w_valid = 1; m0_b_ready = 1;
        m1_aw_valid = 1; m1_w_valid = 1; m1_b_ready = 1;
        s_aw_ready = 1; s_w_ready = 1;
        cyc(); @(negedge clk);
        check("t6_tie_m0", grant, 2'b01);
        cyc(); s_b_valid = 1;
        cyc(); clear_inputs();
        cyc();

        // Randomized run with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst_n = ($urandom_range(0, 249) != 0);
            randomize_inputs();
        end
        cyc(); rst_n = 1'b1; clear_inputs();
        repeat (3) cyc();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
